ahb_slave_regbank: RTL and testbench
====================================

// Module: ahb_slave_regbank
// PURPOSE
// - AHB-lite responder: word-addressed register bank that services transfers issued by the
//   comm controller's AHB-lite master (UART/scan-driven debug access).
// - Supports byte, halfword and word accesses with lane-correct writes.
// - Supports programmable wait states and two-cycle ERROR responses.
// - Used as a bring-up/scratch target and as the bench endpoint for the master path.
// PARAMETERS
// - AW        32             address width
// - DW        32             data width; only 32 is supported
// - DEPTH     64             number of 32-bit registers; power of 2, at least 4
// - BASE      32'h4000_0000  byte address of register 0; must be aligned to DEPTH*4
// - WAIT_CYC  0              wait states inserted per OKAY transfer; range 0..15
// PORTS
// - clk     in   1      clock
// - rst     in   1      asynchronous reset, active-high
// - hsel    in   1      slave select
// - haddr   in   AW     address-phase address
// - htrans  in   2      IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
// - hwrite  in   1      1 = write
// - hsize   in   3      000 = byte, 001 = halfword, 010 = word
// - hwdata  in   DW     data-phase write data
// - hrdata  out  DW     data-phase read data
// - hready  out  1      0 = stall the current data phase
// - hresp   out  1      1 = ERROR
// BEHAVIOUR
// - Reset (async, on rst=1):
//   - hready=1, hresp=0, hrdata=0, state=IDLE, wait counter=0.
//   - All registers cleared to 0.
//   - Reset asserted mid-transfer aborts the transfer and does not update memory.
// - Address-phase accept: on a clk edge with hsel & htrans[1] & hready.
//   - Captures haddr, hwrite and hsize, then starts the data phase in the next cycle.
//   - IDLE, BUSY or hsel=0 start nothing; those cycles see hready=1, hresp=0.
// - Error check, made at accept time. The transfer is an error if any of:
//   - hsize > 3'b010;
//   - haddr is misaligned to hsize (halfword: haddr[0]!=0; word: haddr[1:0]!=0);
//   - (haddr - BASE) >= DEPTH*4 (this check applies only when the macro is enabled).
// - FSM states: IDLE, DATA, ERR1, ERR2.
//   - IDLE -> DATA on an accepted OKAY transfer; the counter loads WAIT_CYC.
//   - IDLE -> ERR1 on an accepted error transfer.
//   - DATA:
//     - hready = (cnt==0); the counter decrements while cnt != 0.
//     - At cnt==0 the transfer completes, and the state follows the accept rules above
//       (to DATA, ERR1 or IDLE).
//   - ERR1: hready=0, hresp=1; always -> ERR2.
//   - ERR2: hready=1, hresp=1.
//     - An address phase sampled here is accepted normally (the master may also drive IDLE).
//     - Next state follows the accept rules; otherwise IDLE.
// - Latency: an OKAY transfer takes 1 + WAIT_CYC data-phase cycles; an error transfer takes 2.
// - Write: performed on the completion edge of DATA, using hwdata.
//   - Byte lane(s) are selected by hsize and captured haddr[1:0]; other lanes are unchanged.
//   - Errored writes never modify memory.
// - Read: hrdata = mem[idx] during the completion cycle (hready=1, hresp=0); 0 in all other cycles.
//   - The full word is returned; the master selects lanes.
// - idx = (haddr - BASE) >> 2, truncated to log2(DEPTH) bits (wraps within the bank).
// - Back-to-back write then read to the same word with WAIT_CYC=0: the read returns the new data.
//   The write commits on the edge that starts the read's data phase.
// - hresp=1 only in ERR1 and ERR2; hresp is never asserted while hready=1 in DATA.
// CONFIGURATION
// - AHB_SLV_RANGE_ERR_EN defined: an out-of-window address gives a two-cycle ERROR;
//   the write is dropped and no read data is returned.
// - Not defined: no range check. The address wraps modulo DEPTH into the bank, and the access
//   completes OKAY with normal wait states. Size and alignment errors still apply.
// TESTING
// - Write then read: WAIT_CYC=0; write word 0xDEADBEEF @BASE+0x8, then read @BASE+0x8
//   -> hrdata=0xDEADBEEF, hready never low, hresp=0.
// - Byte write: word 0x11223344 @BASE+0x4; byte write hwdata=0xAA000000 @BASE+0x7
//   -> a word read returns 0xAA223344.
// - Wait states: WAIT_CYC=3, read @BASE
//   -> hready low for exactly 3 cycles, then high with data; hresp=0 throughout.
// - Misaligned access: word write @BASE+0x2
//   -> ERR1 (hready=0, hresp=1), ERR2 (hready=1, hresp=1); memory unchanged.
// - Out of range: read @BASE+DEPTH*4
//   -> with the macro: ERROR pair; without it: data of register 0, OKAY.
// - Reset mid-transfer: rst pulsed during a DATA wait
//   -> hready=1, hresp=0, hrdata=0 immediately; subsequent reads return 0.

Source files
------------

// File: rtl/ahb_slave_regbank.sv
// AHB-lite word-addressed register bank with programmable wait states and two-cycle ERROR responses.
// Define AHB_SLV_RANGE_ERR_EN to turn accesses outside the DEPTH*4 byte window into ERROR responses.
module ahb_slave_regbank #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 64,
    parameter logic [AW-1:0] BASE     = 32'h4000_0000,
    parameter int            WAIT_CYC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [DW-1:0] hwdata,
    output logic [DW-1:0] hrdata,
    output logic          hready,
    output logic          hresp
);

    localparam int         IW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    // Handshake: a transfer is accepted when hsel & htrans[1] & hready are all high on a clk edge;
    // its data phase completes on the first later edge at which hready is high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    state_t          accept_state;
    logic [3:0]      cnt;
    logic [IW-1:0]   cap_idx;
    logic [1:0]      cap_lane;
    logic [1:0]      cap_size;
    logic            cap_write;
    logic [DW-1:0]   mem [DEPTH];

    logic            accept;
    logic [AW-1:0]   offset;
    logic            size_err;
    logic            align_err;
    logic            range_err;
    logic            xfer_err;
    logic            done;
    logic [3:0]      byte_en;

    assign accept = hsel & htrans[1] & hready;
    assign offset = haddr - BASE;

    assign size_err  = (hsize > 3'b010);
    assign align_err = ((hsize == 3'b001) && haddr[0]) ||
                       ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

`ifdef AHB_SLV_RANGE_ERR_EN
    localparam logic [AW-1:0] WINDOW = AW'(DEPTH * 4);
    assign range_err = (offset >= WINDOW);
`else
    // Without the range check the index simply wraps, so the upper offset bits are don't-care.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[AW-1:IW+2], offset[1:0]};
    assign range_err = 1'b0;
`endif

    assign xfer_err     = size_err | align_err | range_err;
    assign accept_state = xfer_err ? S_ERR1 : S_DATA;
    assign done         = (state == S_DATA) && (cnt == 4'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = accept ? accept_state : S_IDLE;
            S_DATA: begin
                if (cnt == 4'd0) begin
                    state_nxt = accept ? accept_state : S_IDLE;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
            S_ERR2: state_nxt = accept ? accept_state : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        case (state)
            S_IDLE: begin
                hready = 1'b1;
                hresp  = 1'b0;
            end
            S_DATA: begin
                hready = (cnt == 4'd0);
                hresp  = 1'b0;
                if ((cnt == 4'd0) && !cap_write) begin
                    hrdata = mem[cap_idx];
                end
            end
            S_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            S_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
            default: begin
                hready = 1'b1;
                hresp  = 1'b0;
            end
        endcase
    end

    // Address-phase capture and wait-state counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 4'd0;
            cap_idx   <= '0;
            cap_lane  <= 2'b00;
            cap_size  <= 2'b00;
            cap_write <= 1'b0;
        end else begin
            if (accept) begin
                cap_idx   <= offset[IW+1:2];
                cap_lane  <= haddr[1:0];
                cap_size  <= hsize[1:0];
                cap_write <= hwrite;
            end
            if (accept && !xfer_err) begin
                cnt <= WAIT_INIT;
            end else if ((state == S_DATA) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Lane enables; errored transfers never reach S_DATA, so cap_size is always legal here.
    always_comb begin
        byte_en = 4'b0000;
        case (cap_size)
            2'b00:   byte_en[cap_lane] = 1'b1;
            2'b01:   byte_en = cap_lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // Register array: writes commit on the completion edge of the data phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (done && cap_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[cap_idx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_regbank.sv
// Bench for ahb_slave_regbank: two instances (0 and 3 wait states) on a shared bus, directed and random transfers.
module tb_ahb_slave_regbank;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          sel;

    logic        hsel0, hsel3;
    logic [31:0] hrdata0, hrdata3, hrdata;
    logic        hready0, hready3, hready;
    logic        hresp0, hresp3, hresp;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign hsel0  = hsel && (sel == 0);
    assign hsel3  = hsel && (sel == 1);
    assign hrdata = (sel == 1) ? hrdata3 : hrdata0;
    assign hready = (sel == 1) ? hready3 : hready0;
    assign hresp  = (sel == 1) ? hresp3  : hresp0;

    ahb_slave_regbank #(.WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
    );

    ahb_slave_regbank #(.WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .hsel(hsel3), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata3), .hready(hready3), .hresp(hresp3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] off;
        int nb;
        off = addr - BASE;
        if (size > 3'd2) return 1'b1;
        nb = 1 << size;
        if ((addr % nb) != 0) return 1'b1;
`ifdef AHB_SLV_RANGE_ERR_EN
        if (off >= 32'(DEPTH * 4)) return 1'b1;
`endif
        return (off === 32'hxxxx_xxxx);
    endfunction

    function automatic int model_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'((off / 4) % DEPTH);
    endfunction

    task automatic model_write(input int d, input logic [31:0] addr, input logic [2:0] size,
                               input logic [31:0] wdata);
        logic [31:0] w;
        int idx, b, nb;
        idx = model_idx(addr);
        w   = model_mem[d][idx];
        b   = addr % 4;
        nb  = 1 << size;
        for (int k = 0; k < nb; k++) begin
            w[8*(b+k) +: 8] = wdata[8*(b+k) +: 8];
        end
        model_mem[d][idx] = w;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[d][i] = 32'h0;
            end
        end
    endtask

    // Called #1 after a posedge, with the bus idle or the previous transfer in its final cycle.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int ncyc,
                        output bit r_or, output bit r_and, output bit stall_data);
        hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
        ncyc = 0; r_or = 1'b0; r_and = 1'b1; stall_data = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ncyc++;
            r_or  = r_or | hresp;
            r_and = r_and & hresp;
            if (hready) break;
            if (hrdata !== 32'h0) stall_data = 1'b1;
            @(posedge clk); #1;
        end
        rdata = hrdata;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic run(input int d, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rd);
        bit err, r_or, r_and, stall_data;
        int ncyc, waits;
        logic [31:0] expv;
        sel   = d;
        waits = (d == 1) ? 3 : 0;
        err   = model_err(addr, size);
        if (!wr && !err) exp_q.push_back(model_mem[d][model_idx(addr)]);
        xfer(addr, wr, size, wdata, rd, ncyc, r_or, r_and, stall_data);
        check("hready_done", hready, 1'b1);
        check("stall_rdata_zero", stall_data, 1'b0);
        if (err) begin
            check("err_cycles", ncyc, 2);
            check("err_resp", r_and, 1'b1);
            check("err_rdata", rd, 32'h0);
        end else begin
            check("okay_cycles", ncyc, 1 + waits);
            check("okay_resp", r_or, 1'b0);
            if (wr) begin
                check("write_rdata", rd, 32'h0);
                model_write(d, addr, size, wdata);
            end else begin
                expv = exp_q.pop_front();
                check("read_data", rd, expv);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, addr, wdata;
        logic [2:0]  size;
        bit          wr;
        int          d;

        rst = 1'b1; sel = 0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'b010; hwdata = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hready0", hready0, 1'b1);
        check("rst_hresp0", hresp0, 1'b0);
        check("rst_hrdata0", hrdata0, 32'h0);
        check("rst_hready3", hready3, 1'b1);
        check("rst_hresp3", hresp3, 1'b0);
        check("rst_hrdata3", hrdata3, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write then read back-to-back, zero wait states
        run(0, BASE + 32'h8, 1'b1, 3'b010, 32'hDEAD_BEEF, rd);
        run(0, BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd);
        check("wr_rd_const", rd, 32'hDEAD_BEEF);

        // Byte and halfword lane writes
        run(0, BASE + 32'h4, 1'b1, 3'b010, 32'h1122_3344, rd);
        run(0, BASE + 32'h7, 1'b1, 3'b000, 32'hAA00_0000, rd);
        run(0, BASE + 32'h4, 1'b0, 3'b010, 32'h0, rd);
        check("byte_lane_const", rd, 32'hAA22_3344);
        run(0, BASE + 32'h4, 1'b1, 3'b001, 32'h0000_BEEF, rd);
        run(0, BASE + 32'h4, 1'b0, 3'b000, 32'h0, rd);
        check("half_lane_const", rd, 32'hAA22_BEEF);

        // Wait states on the 3-cycle instance
        run(1, BASE + 32'h0, 1'b1, 3'b010, 32'h1234_5678, rd);
        run(1, BASE + 32'h0, 1'b0, 3'b010, 32'h0, rd);
        check("wait_read_const", rd, 32'h1234_5678);

        // Size and alignment errors leave memory untouched
        run(0, BASE + 32'h2, 1'b1, 3'b010, 32'hFFFF_FFFF, rd);
        run(0, BASE + 32'h1, 1'b1, 3'b001, 32'hFFFF_FFFF, rd);
        run(0, BASE + 32'h0, 1'b1, 3'b011, 32'hFFFF_FFFF, rd);
        run(0, BASE + 32'h0, 1'b0, 3'b010, 32'h0, rd);
        check("misaligned_unchanged", rd, 32'h0);

        // Out-of-window access
        run(0, BASE + 32'h0, 1'b1, 3'b010, 32'h0BAD_F00D, rd);
        run(0, BASE + 32'(DEPTH * 4), 1'b0, 3'b010, 32'h0, rd);
`ifdef AHB_SLV_RANGE_ERR_EN
        check("range_const", rd, 32'h0);
`else
        check("range_const", rd, 32'h0BAD_F00D);
`endif

        // Randomised traffic across both instances
        for (int n = 0; n < 300; n++) begin
            d     = ($urandom_range(0, 3) == 0) ? 1 : 0;
            addr  = BASE + 32'($urandom_range(0, 2 * DEPTH * 4 - 1));
            size  = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
            wr    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            run(d, addr, wr, size, wdata, rd);
        end

        // Full sweep of the zero-wait instance
        for (int i = 0; i < DEPTH; i++) begin
            run(0, BASE + 32'(i * 4), 1'b0, 3'b010, 32'h0, rd);
        end

        // Reset during a wait state of a read
        run(1, BASE + 32'h4, 1'b1, 3'b010, 32'hCAFE_0001, rd);
        bus_idle();
        sel = 1;
        hsel = 1'b1; htrans = 2'b10; haddr = BASE + 32'h4; hwrite = 1'b0; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00;
        check("pre_rst_stall", hready, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_hready", hready3, 1'b1);
        check("mid_rst_hresp", hresp3, 1'b0);
        check("mid_rst_hrdata", hrdata3, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        @(posedge clk); #1;
        run(1, BASE + 32'h4, 1'b0, 3'b010, 32'h0, rd);
        check("post_rst_read3", rd, 32'h0);
        run(0, BASE + 32'h8, 1'b0, 3'b010, 32'h0, rd);
        check("post_rst_read0", rd, 32'h0);
        bus_idle();

        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
